// File: rtl/brightness_pe_row.sv
// One row of the brightness systolic array: captures a DEPTH-lane block, runs it through skewed
// saturating add PEs and writes results out. Define BRIGHT_CLIP_STATS_EN to enable the clip counters.

module brightness_pe #(
   parameter int PIX_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic [PIX_WIDTH-1:0]       pix,
   input  logic signed [PIX_WIDTH:0]  offset,
   output logic [PIX_WIDTH-1:0]       res_q
`ifdef BRIGHT_CLIP_STATS_EN
   ,
   output logic                       clip_hi,
   output logic                       clip_lo
`endif
);
   localparam logic signed [PIX_WIDTH+1:0] PIX_MAX = {2'b00, {PIX_WIDTH{1'b1}}};

   logic signed [PIX_WIDTH+1:0] sum;
   logic                        sat_hi, sat_lo;
   logic [PIX_WIDTH-1:0]        res_d;

   always_comb begin
      sum    = $signed({2'b00, pix}) + $signed({offset[PIX_WIDTH], offset});
      sat_lo = sum[PIX_WIDTH+1];
      sat_hi = sum > PIX_MAX;
      res_d  = sum[PIX_WIDTH-1:0];
      if (sat_lo)      res_d = '0;
      else if (sat_hi) res_d = '1;
   end

`ifdef BRIGHT_CLIP_STATS_EN
   assign clip_hi = sat_hi;
   assign clip_lo = sat_lo;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)  res_q <= '0;
      else if (en) res_q <= res_d;
   end
endmodule

module brightness_pe_row #(
   parameter int PE_DATA_WIDTH  = 16,
   parameter int DEPTH          = 4,
   parameter int PIX_WIDTH      = 8,
   parameter int OUT_ADDR_WIDTH = 6,
   parameter int NUM_BLOCKS     = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic signed [PIX_WIDTH:0]       offset,
   input  logic [PE_DATA_WIDTH*DEPTH-1:0]  data_in,
   input  logic                            data_valid,
   input  logic                            load_next,
   output logic                            tpu_ready,
   output logic                            wr_en,
   output logic [OUT_ADDR_WIDTH-1:0]       wr_addr,
   output logic [PIX_WIDTH-1:0]            wr_data,
   output logic                            busy,
   output logic                            frame_done,
   output logic [15:0]                     clip_hi_count,
   output logic [15:0]                     clip_lo_count
);
   localparam int CNT_W = $clog2(NUM_BLOCKS + 1);

   typedef enum logic [1:0] {IDLE, COMPUTE, HANDSHAKE, FINISH} state_t;

   state_t                              state_q, state_d;
   logic [DEPTH-1:0][PIX_WIDTH-1:0]     pix_q, pix_d, pe_res;
   logic signed [PIX_WIDTH:0]           off_q, off_d;
   logic [DEPTH:0]                      vld_pipe_q, vld_pipe_d;
   logic [CNT_W-1:0]                    cnt_q, cnt_d;
   logic [OUT_ADDR_WIDTH-1:0]           base_q, base_d, wr_addr_q, wr_addr_d;
   logic [PIX_WIDTH-1:0]                wr_data_q, wr_data_d;
   logic                                tpu_ready_q, tpu_ready_d, wr_en_q, wr_en_d;

`ifdef BRIGHT_CLIP_STATS_EN
   logic [DEPTH-1:0] clip_hi_vec, clip_lo_vec;
`endif

   // vld_pipe_q[i] enables PE i; vld_pipe_q[i+1] selects lane i for the registered write
   for (genvar g = 0; g < DEPTH; g++) begin : g_pe
      brightness_pe #(.PIX_WIDTH(PIX_WIDTH)) u_pe (
         .clk     (clk),
         .reset   (reset),
         .en      (vld_pipe_q[g]),
         .pix     (pix_q[g]),
         .offset  (off_q),
         .res_q   (pe_res[g])
`ifdef BRIGHT_CLIP_STATS_EN
         ,
         .clip_hi (clip_hi_vec[g]),
         .clip_lo (clip_lo_vec[g])
`endif
      );
   end

   always_comb begin
      state_d     = state_q;
      pix_d       = pix_q;
      off_d       = off_q;
      cnt_d       = cnt_q;
      base_d      = base_q;
      vld_pipe_d  = {vld_pipe_q[DEPTH-1:0], 1'b0};
      tpu_ready_d = 1'b0;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_pipe_q[i+1]) begin
            wr_en_d   = 1'b1;
            wr_addr_d = base_q + OUT_ADDR_WIDTH'(i);
            wr_data_d = pe_res[i];
         end
      end
      case (state_q)
         IDLE: begin
            // start clears first so a same-cycle block lands as block 0
            if (start) begin
               cnt_d  = '0;
               base_d = '0;
            end
            if (data_valid) begin
               for (int i = 0; i < DEPTH; i++) pix_d[i] = data_in[i*PE_DATA_WIDTH +: PIX_WIDTH];
               off_d         = offset;
               vld_pipe_d[0] = 1'b1;
               state_d       = COMPUTE;
            end
         end
         COMPUTE: if (vld_pipe_q[DEPTH]) state_d = HANDSHAKE;
         HANDSHAKE: begin
            if (load_next) begin
               tpu_ready_d = 1'b1;
               cnt_d       = cnt_q + 1'b1;
               base_d      = base_q + OUT_ADDR_WIDTH'(DEPTH);
               state_d     = (cnt_d == CNT_W'(NUM_BLOCKS)) ? FINISH : IDLE;
            end
         end
         FINISH: begin
            cnt_d   = '0;
            base_d  = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         pix_q       <= '0;
         off_q       <= '0;
         vld_pipe_q  <= '0;
         cnt_q       <= '0;
         base_q      <= '0;
         tpu_ready_q <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         pix_q       <= pix_d;
         off_q       <= off_d;
         vld_pipe_q  <= vld_pipe_d;
         cnt_q       <= cnt_d;
         base_q      <= base_d;
         tpu_ready_q <= tpu_ready_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   assign tpu_ready  = tpu_ready_q;
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign busy       = (state_q != IDLE);
   assign frame_done = (state_q == FINISH);

`ifdef BRIGHT_CLIP_STATS_EN
   logic        start_ok;
   logic [15:0] clip_hi_q, clip_hi_d, clip_lo_q, clip_lo_d;

   assign start_ok = (state_q == IDLE) && start;

   // only one PE is enabled per edge, so each counter moves by at most one
   always_comb begin
      clip_hi_d = clip_hi_q;
      clip_lo_d = clip_lo_q;
      if (start_ok) begin
         clip_hi_d = '0;
         clip_lo_d = '0;
      end else begin
         if (|(clip_hi_vec & vld_pipe_q[DEPTH-1:0]) && clip_hi_q != 16'hFFFF) clip_hi_d = clip_hi_q + 16'd1;
         if (|(clip_lo_vec & vld_pipe_q[DEPTH-1:0]) && clip_lo_q != 16'hFFFF) clip_lo_d = clip_lo_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clip_hi_q <= '0;
         clip_lo_q <= '0;
      end else begin
         clip_hi_q <= clip_hi_d;
         clip_lo_q <= clip_lo_d;
      end
   end

   assign clip_hi_count = clip_hi_q;
   assign clip_lo_count = clip_lo_q;
`else
   assign clip_hi_count = '0;
   assign clip_lo_count = '0;
`endif
endmodule

// File: tb/tb_brightness_pe_row.sv
// Self-checking bench for brightness_pe_row: randomized blocks against a behavioural frame/pixel model.
module tb_brightness_pe_row;
   logic               clk = 1'b0, reset = 1'b0, start = 1'b0, data_valid = 1'b0, load_next = 1'b0;
   logic signed [8:0]  offset = '0;
   logic [63:0]        data_in = '0;
   logic               tpu_ready, wr_en, busy, frame_done;
   logic [5:0]         wr_addr;
   logic [7:0]         wr_data;
   logic [15:0]        clip_hi_count, clip_lo_count;

   brightness_pe_row dut (
      .clk(clk), .reset(reset), .start(start), .offset(offset), .data_in(data_in),
      .data_valid(data_valid), .load_next(load_next), .tpu_ready(tpu_ready), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .frame_done(frame_done),
      .clip_hi_count(clip_hi_count), .clip_lo_count(clip_lo_count));

   always #5 clk = ~clk;

   int errors = 0, checks = 0;
   int edge_n = 0;
   int q_addr[$], q_data[$], q_edge[$];
   int tr_cnt = 0, tr_edge = 0, fd_cnt = 0, fd_edge = 0;
   // model: block index within frame, clip tallies, expected pixels of current block
   int mdl_blk = 0, mdl_hi = 0, mdl_lo = 0;
   int exp_pix[4];

   always @(posedge clk) edge_n++;

   always begin
      @(posedge clk);
      #2;
      if (wr_en) begin q_addr.push_back(int'(wr_addr)); q_data.push_back(int'(wr_data)); q_edge.push_back(edge_n); end
      if (tpu_ready) begin tr_cnt++; tr_edge = edge_n; end
      if (frame_done) begin fd_cnt++; fd_edge = edge_n; end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic model_block(input logic [3:0][15:0] lanes, input int off);
      for (int i = 0; i < 4; i++) begin
         int s;
         s = int'(lanes[i][7:0]) + off;
         exp_pix[i] = (s < 0) ? 0 : (s > 255) ? 255 : s;
         if (s > 255) mdl_hi++;
         if (s < 0) mdl_lo++;
      end
   endtask

   function automatic int exp_hi();
`ifdef BRIGHT_CLIP_STATS_EN
      return mdl_hi;
`else
      return 0;
`endif
   endfunction

   function automatic int exp_lo();
`ifdef BRIGHT_CLIP_STATS_EN
      return mdl_lo;
`else
      return 0;
`endif
   endfunction

   task automatic send(input logic [3:0][15:0] lanes, input int off, input bit with_start, output int e0);
      q_addr.delete(); q_data.delete(); q_edge.delete();
      tr_cnt = 0; fd_cnt = 0;
      @(negedge clk);
      data_in = lanes; offset = 9'(off); data_valid = 1'b1; start = with_start;
      e0 = edge_n + 1;
      @(negedge clk);
      data_valid = 1'b0; start = 1'b0;
   endtask

   task automatic wait_writes(input int n, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         if (q_addr.size() >= n) ok = 1'b1;
      end
   endtask

   task automatic pulse_ln(input int delay, input int hold, output int ln_edge);
      repeat (delay) @(negedge clk);
      load_next = 1'b1;
      ln_edge = edge_n + 1;
      repeat (hold) @(negedge clk);
      load_next = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if ({wr_en, tpu_ready, busy, frame_done} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 0000", {wr_en, tpu_ready, busy, frame_done}); end
      checks++; if ({wr_addr, wr_data} !== 14'd0) begin errors++; $display("FAIL reset_wr: addr=%0d data=%0d want 0", wr_addr, wr_data); end
      checks++; if ({clip_hi_count, clip_lo_count} !== 32'd0) begin errors++; $display("FAIL reset_clip: hi=%0d lo=%0d want 0", clip_hi_count, clip_lo_count); end
      reset = 1'b1;
      mdl_blk = 0; mdl_hi = 0; mdl_lo = 0;
      @(negedge clk);
   endtask

   task automatic test_basic;
      logic [3:0][15:0] lanes;
      int e0;
      bit ok;
      lanes = {16'h0004, 16'h0003, 16'h0002, 16'h0009};
      mdl_blk = 0; mdl_hi = 0; mdl_lo = 0;
      model_block(lanes, 10);
      load_next = 1'b1;
      send(lanes, 10, 1'b1, e0);
      wait_writes(4, ok);
      repeat (3) @(negedge clk);
      load_next = 1'b0;
      checks++; if (!ok || q_addr.size() != 4) begin errors++; $display("FAIL basic_count: got %0d writes want 4", q_addr.size()); end
      for (int i = 0; i < q_addr.size() && i < 4; i++) begin
         checks++;
         if (q_addr[i] !== i || q_data[i] !== exp_pix[i] || q_edge[i] !== e0 + 2 + i) begin
            errors++;
            $display("FAIL basic_w%0d: addr=%0d data=%0d edge=%0d want addr=%0d data=%0d edge=%0d",
                     i, q_addr[i], q_data[i], q_edge[i], i, exp_pix[i], e0 + 2 + i);
         end
      end
      checks++; if (tr_cnt !== 1 || tr_edge !== e0 + 6) begin errors++; $display("FAIL basic_ready: count=%0d edge=%0d want 1 at %0d", tr_cnt, tr_edge, e0 + 6); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", busy); end
      mdl_blk = (mdl_blk + 1) % 16;
   endtask

   task automatic test_saturate;
      logic [3:0][15:0] lanes;
      int offs[2];
      int e0, ln;
      bit ok;
      lanes = {16'h0000, 16'h0009, 16'h00FF, 16'h00C8};
      offs[0] = 100; offs[1] = -20;
      for (int b = 0; b < 2; b++) begin
         model_block(lanes, offs[b]);
         send(lanes, offs[b], 1'b0, e0);
         wait_writes(4, ok);
         checks++; if (!ok) begin errors++; $display("FAIL sat_timeout: got %0d writes want 4", q_addr.size()); end
         for (int i = 0; i < q_addr.size() && i < 4; i++) begin
            checks++;
            if (q_addr[i] !== (mdl_blk * 4 + i) % 64 || q_data[i] !== exp_pix[i]) begin
               errors++;
               $display("FAIL sat_b%0d_w%0d: addr=%0d data=%0d want addr=%0d data=%0d",
                        b, i, q_addr[i], q_data[i], (mdl_blk * 4 + i) % 64, exp_pix[i]);
            end
         end
         checks++; if (clip_hi_count !== 16'(exp_hi()) || clip_lo_count !== 16'(exp_lo())) begin
            errors++; $display("FAIL sat_clip_b%0d: hi=%0d lo=%0d want hi=%0d lo=%0d", b, clip_hi_count, clip_lo_count, exp_hi(), exp_lo());
         end
         pulse_ln(0, 1, ln);
         mdl_blk = (mdl_blk + 1) % 16;
      end
   endtask

   task automatic test_delayed_handshake;
      logic [3:0][15:0] lanes;
      int off, e0, ln;
      bit ok;
      lanes = {$urandom, $urandom};
      off = int'($urandom_range(0, 511)) - 256;
      model_block(lanes, off);
      send(lanes, off, 1'b0, e0);
      wait_writes(4, ok);
      repeat (5) @(negedge clk);
      checks++; if (tr_cnt !== 0 || busy !== 1'b1) begin errors++; $display("FAIL delay_wait: ready_count=%0d busy=%b want 0 and 1", tr_cnt, busy); end
      pulse_ln(0, 3, ln);
      checks++; if (tr_cnt !== 1 || tr_edge !== ln) begin errors++; $display("FAIL delay_ready: count=%0d edge=%0d want 1 at %0d", tr_cnt, tr_edge, ln); end
      for (int i = 0; i < q_addr.size() && i < 4; i++) begin
         checks++;
         if (q_data[i] !== exp_pix[i]) begin errors++; $display("FAIL delay_w%0d: data=%0d want %0d", i, q_data[i], exp_pix[i]); end
      end
      mdl_blk = (mdl_blk + 1) % 16;
   endtask

   task automatic test_ignored;
      logic [3:0][15:0] lanes;
      int off, e0, ln;
      bit ok;
      lanes = {$urandom, $urandom};
      off = int'($urandom_range(0, 511)) - 256;
      model_block(lanes, off);
      send(lanes, off, 1'b0, e0);
      @(negedge clk);
      data_in = ~lanes; offset = 9'(off + 37); data_valid = 1'b1; start = 1'b1;
      @(negedge clk);
      data_valid = 1'b0; start = 1'b0;
      wait_writes(4, ok);
      pulse_ln(1, 1, ln);
      repeat (4) @(negedge clk);
      checks++; if (q_addr.size() !== 4) begin errors++; $display("FAIL ignore_count: got %0d writes want 4", q_addr.size()); end
      for (int i = 0; i < q_addr.size() && i < 4; i++) begin
         checks++;
         if (q_addr[i] !== (mdl_blk * 4 + i) % 64 || q_data[i] !== exp_pix[i]) begin
            errors++;
            $display("FAIL ignore_w%0d: addr=%0d data=%0d want addr=%0d data=%0d", i, q_addr[i], q_data[i], (mdl_blk * 4 + i) % 64, exp_pix[i]);
         end
      end
      mdl_blk = (mdl_blk + 1) % 16;
   endtask

   task automatic test_frame;
      logic [3:0][15:0] lanes;
      int off, e0, ln, exp_fd;
      bit ok;
      for (int b = 0; b < 17; b++) begin
         lanes = {$urandom, $urandom};
         off = int'($urandom_range(0, 511)) - 256;
         if (b == 0) begin mdl_blk = 0; mdl_hi = 0; mdl_lo = 0; end
         model_block(lanes, off);
         send(lanes, off, b == 0, e0);
         wait_writes(4, ok);
         checks++; if (!ok) begin errors++; $display("FAIL frame_timeout_b%0d: got %0d writes want 4", b, q_addr.size()); end
         for (int i = 0; i < q_addr.size() && i < 4; i++) begin
            checks++;
            if (q_addr[i] !== (mdl_blk * 4 + i) % 64 || q_data[i] !== exp_pix[i]) begin
               errors++;
               $display("FAIL frame_b%0d_w%0d: addr=%0d data=%0d want addr=%0d data=%0d",
                        b, i, q_addr[i], q_data[i], (mdl_blk * 4 + i) % 64, exp_pix[i]);
            end
         end
         if (b == 15) begin
            checks++; if (q_addr.size() != 4 || q_addr[3] !== 63) begin errors++; $display("FAIL frame_last_addr: writes=%0d want last addr 63", q_addr.size()); end
         end
         pulse_ln(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), ln);
         checks++; if (tr_cnt !== 1 || tr_edge !== ln) begin errors++; $display("FAIL frame_ready_b%0d: count=%0d edge=%0d want 1 at %0d", b, tr_cnt, tr_edge, ln); end
         mdl_blk = (mdl_blk + 1) % 16;
         exp_fd = (mdl_blk == 0) ? 1 : 0;
         checks++; if (fd_cnt !== exp_fd || (exp_fd == 1 && fd_edge !== tr_edge)) begin
            errors++; $display("FAIL frame_done_b%0d: count=%0d edge=%0d want %0d at %0d", b, fd_cnt, fd_edge, exp_fd, tr_edge);
         end
      end
      checks++; if (clip_hi_count !== 16'(exp_hi()) || clip_lo_count !== 16'(exp_lo())) begin
         errors++; $display("FAIL frame_clip: hi=%0d lo=%0d want hi=%0d lo=%0d", clip_hi_count, clip_lo_count, exp_hi(), exp_lo());
      end
   endtask

   task automatic test_reset_mid;
      logic [3:0][15:0] lanes;
      int off, e0, ln;
      bit ok;
      lanes = {$urandom, $urandom};
      off = int'($urandom_range(0, 511)) - 256;
      send(lanes, off, 1'b0, e0);
      wait_writes(2, ok);
      reset = 1'b0;
      #1;
      checks++; if (!ok || {wr_en, tpu_ready, busy} !== 3'b0) begin errors++; $display("FAIL midrst_out: wr_en/ready/busy=%b want 000", {wr_en, tpu_ready, busy}); end
      load_next = 1'b1;
      repeat (4) @(negedge clk);
      checks++; if (q_addr.size() !== 2 || tr_cnt !== 0) begin errors++; $display("FAIL midrst_abort: writes=%0d ready=%0d want 2 and 0", q_addr.size(), tr_cnt); end
      load_next = 1'b0;
      reset = 1'b1;
      mdl_blk = 0; mdl_hi = 0; mdl_lo = 0;
      @(negedge clk);
      lanes = {$urandom, $urandom};
      off = int'($urandom_range(0, 511)) - 256;
      model_block(lanes, off);
      send(lanes, off, 1'b0, e0);
      wait_writes(4, ok);
      for (int i = 0; i < q_addr.size() && i < 4; i++) begin
         checks++;
         if (q_addr[i] !== i || q_data[i] !== exp_pix[i]) begin
            errors++; $display("FAIL midrst_w%0d: addr=%0d data=%0d want addr=%0d data=%0d", i, q_addr[i], q_data[i], i, exp_pix[i]);
         end
      end
      pulse_ln(0, 1, ln);
      checks++; if (tr_cnt !== 1 || clip_hi_count !== 16'(exp_hi()) || clip_lo_count !== 16'(exp_lo())) begin
         errors++; $display("FAIL midrst_end: ready=%0d hi=%0d lo=%0d want 1 %0d %0d", tr_cnt, clip_hi_count, clip_lo_count, exp_hi(), exp_lo());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturate();
      test_delayed_handshake();
      test_ignored();
      test_frame();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
